// File: rtl/led_serial_shifter.sv
// Parallel-to-serial driver for daisy-chained 74HC164-style LED shift registers.
// One frame: clear, shift DATA_BITS bits MSB-first with a generated s_clk, then enable outputs.
module led_serial_shifter #(
  parameter int DATA_BITS       = 16,
  parameter int DATA_COUNT_BITS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DATA_BITS-1:0] p_data,
  output logic                 s_clk,
  output logic                 s_clrn,
  output logic                 s_out,
  output logic                 pen,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {IDLE, CLEAR, SHIFT, DONE} state_t;

  state_t                     state, state_n;
  logic                       phase, phase_n;
  logic [DATA_COUNT_BITS-1:0] cnt, cnt_n;
  logic [DATA_BITS-1:0]       sreg, sreg_n;
  logic                       s_clk_n, s_clrn_n, s_out_n, pen_n, busy_n, done_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      phase  <= 1'b0;
      cnt    <= '0;
      sreg   <= '0;
      s_clk  <= 1'b0;
      s_clrn <= 1'b1;
      s_out  <= 1'b0;
      pen    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      phase  <= phase_n;
      cnt    <= cnt_n;
      sreg   <= sreg_n;
      s_clk  <= s_clk_n;
      s_clrn <= s_clrn_n;
      s_out  <= s_out_n;
      pen    <= pen_n;
      busy   <= busy_n;
      done   <= done_n;
    end
  end

  // Outputs are decoded from the upcoming state so they register in step with it.
  always_comb begin
    state_n  = state;
    phase_n  = phase;
    cnt_n    = cnt;
    sreg_n   = sreg;
    s_clk_n  = s_clk;
    s_clrn_n = s_clrn;
    s_out_n  = s_out;
    pen_n    = pen;
    busy_n   = busy;
    done_n   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          sreg_n   = p_data;
          cnt_n    = DATA_COUNT_BITS'(DATA_BITS - 1);
          state_n  = CLEAR;
          s_clrn_n = 1'b0;
          pen_n    = 1'b0;
          busy_n   = 1'b1;
          s_clk_n  = 1'b0;
          s_out_n  = 1'b0;
        end
      end
      CLEAR: begin
        state_n  = SHIFT;
        phase_n  = 1'b0;
        s_clrn_n = 1'b1;
        s_clk_n  = 1'b0;
        s_out_n  = sreg[DATA_BITS-1];
      end
      SHIFT: begin
        if (!phase) begin
          phase_n = 1'b1;
          s_clk_n = 1'b1;
        end else begin
          sreg_n  = {sreg[DATA_BITS-2:0], 1'b0};
          phase_n = 1'b0;
          s_clk_n = 1'b0;
          if (cnt == '0) begin
            state_n = DONE;
            s_out_n = 1'b0;
            pen_n   = 1'b1;
            done_n  = 1'b1;
          end else begin
            cnt_n   = cnt - 1'b1;
            // Next MSB is presented before the shift takes effect.
            s_out_n = sreg[DATA_BITS-2];
          end
        end
      end
      DONE: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_led_serial_shifter.sv
// Bench for led_serial_shifter: 16-bit and 8-bit instances checked against a frame-level model.
module tb_led_serial_shifter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start16 = 1'b0, start8 = 1'b0;
  logic [15:0] pd16 = '0;
  logic [7:0]  pd8 = '0;
  logic        s_clk16, s_clrn16, s_out16, pen16, busy16, done16;
  logic        s_clk8, s_clrn8, s_out8, pen8, busy8, done8;

  int n_chk = 0, n_pass = 0;
  int cyc = 0, t0;
  logic [63:0] got_bits;
  int got_n, done_n, clr_n, clr_first, stab_bad, pen_rise;
  int done_c[4];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  led_serial_shifter u16 (
    .clk(clk), .rst(rst), .start(start16), .p_data(pd16),
    .s_clk(s_clk16), .s_clrn(s_clrn16), .s_out(s_out16),
    .pen(pen16), .busy(busy16), .done(done16));

  led_serial_shifter #(.DATA_BITS(8), .DATA_COUNT_BITS(3)) u8 (
    .clk(clk), .rst(rst), .start(start8), .p_data(pd8),
    .s_clk(s_clk8), .s_clrn(s_clrn8), .s_out(s_out8),
    .pen(pen8), .busy(busy8), .done(done8));

  // Accepts a frame, then observes spec cycles 1..ncyc, recording what the serial side sees.
  // Optional extra start pulses (pa, pb) and a p_data change (chg_c) land in the given cycle.
  task automatic run(input bit sel, input logic [15:0] d, input bit hold, input int pa,
                     input int pb, input int chg_c, input logic [15:0] chg_d, input int ncyc);
    logic sc, so, dn, cl, pn, pc, po, pp, st;
    got_bits = '0; got_n = 0; done_n = 0; clr_n = 0; clr_first = -1;
    stab_bad = 0; pen_rise = -1;
    @(negedge clk);
    if (sel) begin start8 = 1'b1; pd8 = d[7:0]; end
    else begin start16 = 1'b1; pd16 = d; end
    @(posedge clk); #1;
    t0 = cyc;
    if (!hold) begin start8 = 1'b0; start16 = 1'b0; end
    pc = 1'b0; po = 1'b0;
    pp = sel ? pen8 : pen16;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      sc = sel ? s_clk8 : s_clk16;
      so = sel ? s_out8 : s_out16;
      dn = sel ? done8 : done16;
      cl = sel ? s_clrn8 : s_clrn16;
      pn = sel ? pen8 : pen16;
      if (sc && !pc) begin
        if (so !== po) stab_bad++;
        got_bits = {got_bits[62:0], so};
        got_n++;
      end
      pc = sc; po = so;
      if (dn) begin if (done_n < 4) done_c[done_n] = c; done_n++; end
      if (!cl) begin if (clr_n == 0) clr_first = c; clr_n++; end
      if (pn && !pp) pen_rise = c;
      pp = pn;
      st = hold || c == pa || c == pb;
      if (c == chg_c) begin pd16 = chg_d; pd8 = chg_d[7:0]; end
      if (sel) start8 = st; else start16 = st;
    end
    start8 = 1'b0; start16 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if ({s_clk16, s_clrn16, s_out16, pen16, busy16, done16} !== 6'b010000)
      $display("FAIL reset_hold16 got=%b exp=010000", {s_clk16, s_clrn16, s_out16, pen16, busy16, done16});
    else n_pass++;
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_chk++;
      if ({s_clk16, s_clrn16, s_out16, pen16, busy16, done16, s_clk8, s_clrn8, s_out8, pen8, busy8, done8}
          !== 12'b010000_010000)
        $display("FAIL reset_idle cyc=%0d got=%b exp=010000010000", i,
                 {s_clk16, s_clrn16, s_out16, pen16, busy16, done16, s_clk8, s_clrn8, s_out8, pen8, busy8, done8});
      else n_pass++;
    end
  endtask

  task automatic test_single();
    run(1'b0, 16'hA5C3, 1'b0, -1, -1, -1, 16'h0, 45);
    n_chk++; if (got_n !== 16) $display("FAIL single_edges got=%0d exp=16", got_n); else n_pass++;
    n_chk++; if (got_bits[15:0] !== 16'hA5C3) $display("FAIL single_data got=%h exp=a5c3", got_bits[15:0]); else n_pass++;
    n_chk++; if (clr_n !== 1 || clr_first !== 1) $display("FAIL single_clr got=%0d@%0d exp=1@1", clr_n, clr_first); else n_pass++;
    n_chk++; if (done_n !== 1 || done_c[0] !== 34) $display("FAIL single_done got=%0d@%0d exp=1@34", done_n, done_c[0]); else n_pass++;
    n_chk++; if (pen_rise !== 34 || pen16 !== 1'b1) $display("FAIL single_pen got=%0d/%b exp=34/1", pen_rise, pen16); else n_pass++;
    n_chk++; if (stab_bad !== 0) $display("FAIL single_stable got=%0d exp=0", stab_bad); else n_pass++;
  endtask

  task automatic test_busy_reject();
    run(1'b0, 16'hFFFF, 1'b0, 10, 34, 10, 16'h0001, 45);
    n_chk++; if (got_n !== 16) $display("FAIL busy_edges got=%0d exp=16", got_n); else n_pass++;
    n_chk++; if (got_bits[15:0] !== 16'hFFFF) $display("FAIL busy_data got=%h exp=ffff", got_bits[15:0]); else n_pass++;
    n_chk++; if (done_n !== 1 || clr_n !== 1) $display("FAIL busy_frames got=done%0d/clr%0d exp=1/1", done_n, clr_n); else n_pass++;
  endtask

  task automatic test_back_to_back();
    run(1'b0, 16'h0F0F, 1'b1, -1, -1, 20, 16'h1234, 70);
    n_chk++; if (got_n !== 32) $display("FAIL refresh_edges got=%0d exp=32", got_n); else n_pass++;
    n_chk++; if (got_bits[31:0] !== 32'h0F0F_1234) $display("FAIL refresh_data got=%h exp=0f0f1234", got_bits[31:0]); else n_pass++;
    n_chk++;
    if (done_n !== 2 || done_c[0] !== 34 || done_c[1] !== 69)
      $display("FAIL refresh_done got=%0d@%0d,%0d exp=2@34,69", done_n, done_c[0], done_c[1]);
    else n_pass++;
    n_chk++; if (clr_n !== 2) $display("FAIL refresh_clr got=%0d exp=2", clr_n); else n_pass++;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_mid_reset();
    int bad;
    run(1'b0, 16'hBEEF, 1'b0, -1, -1, -1, 16'h0, 11);
    n_chk++; if (busy16 !== 1'b1) $display("FAIL midrst_busy got=%b exp=1", busy16); else n_pass++;
    @(posedge clk); #2;
    rst = 1'b1; #1;
    n_chk++;
    if ({s_clk16, s_clrn16, s_out16, pen16, busy16, done16} !== 6'b010000)
      $display("FAIL midrst_async got=%b exp=010000", {s_clk16, s_clrn16, s_out16, pen16, busy16, done16});
    else n_pass++;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done16 || busy16 || s_clk16 || !s_clrn16) bad++;
    end
    n_chk++; if (bad !== 0) $display("FAIL midrst_quiet got=%0d exp=0", bad); else n_pass++;
    run(1'b0, 16'h8001, 1'b0, -1, -1, -1, 16'h0, 45);
    n_chk++; if (got_n !== 16 || got_bits[15:0] !== 16'h8001) $display("FAIL midrst_next got=%0d:%h exp=16:8001", got_n, got_bits[15:0]); else n_pass++;
    n_chk++; if (done_n !== 1 || done_c[0] !== 34) $display("FAIL midrst_done got=%0d@%0d exp=1@34", done_n, done_c[0]); else n_pass++;
  endtask

  task automatic test_sweep8();
    run(1'b1, 16'h0081, 1'b0, -1, -1, -1, 16'h0, 30);
    n_chk++; if (got_n !== 8) $display("FAIL sweep_edges got=%0d exp=8", got_n); else n_pass++;
    n_chk++; if (got_bits[7:0] !== 8'b1000_0001) $display("FAIL sweep_data got=%b exp=10000001", got_bits[7:0]); else n_pass++;
    n_chk++; if (done_n !== 1 || done_c[0] !== 18) $display("FAIL sweep_done got=%0d@%0d exp=1@18", done_n, done_c[0]); else n_pass++;
    n_chk++; if (clr_first !== 1 || pen8 !== 1'b1) $display("FAIL sweep_clrpen got=%0d/%b exp=1/1", clr_first, pen8); else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      bit          sel;
      int          n;
      logic [15:0] d, exp_w;
      sel   = 1'($urandom_range(0, 1));
      d     = 16'($urandom);
      n     = sel ? 8 : 16;
      exp_w = sel ? {8'h00, d[7:0]} : d;
      run(sel, d, 1'b0, -1, -1, -1, 16'h0, 2 * n + 8);
      n_chk++;
      if (got_n !== n || got_bits[15:0] !== exp_w)
        $display("FAIL rand%0d_data got=%0d:%h exp=%0d:%h", i, got_n, got_bits[15:0], n, exp_w);
      else n_pass++;
      n_chk++;
      if (done_n !== 1 || done_c[0] !== 2 * n + 2 || stab_bad !== 0)
        $display("FAIL rand%0d_timing got=%0d@%0d/%0d exp=1@%0d/0", i, done_n, done_c[0], stab_bad, 2 * n + 2);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_busy_reject();
    test_back_to_back();
    test_mid_reset();
    test_sweep8();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/led_serial_shifter.md
# led_serial_shifter

Parallel-to-serial driver for the board's daisy-chained LED shift registers (74HC164-style, rising-edge sampled, active-low clear, output-enable gate). It sits directly downstream of the peripheral register block. That block hands it an already bit-ordered, already polarity-corrected DATA_BITS-wide word plus a start request. The driver then performs one frame: clear, shift DATA_BITS bits MSB-first with a generated serial clock, then re-enable the outputs.

## Interface
- DATA_BITS, 16, frame width in bits; legal range 2..64.
- DATA_COUNT_BITS, 4, bit-counter width; must satisfy 2^DATA_COUNT_BITS >= DATA_BITS.
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  frame request, sampled on rising clk; level or pulse.
- p_data  in  DATA_BITS  word to serialize; sampled only in the cycle start is accepted.
- s_clk  out  1  serial clock to the external shift register.
- s_clrn  out  1  active-low clear to the external shift register.
- s_out  out  1  serial data, valid while s_clk rises.
- pen  out  1  external output enable; high = LEDs show register contents.
- busy  out  1  high while a frame is in progress.
- done  out  1  one-cycle pulse at frame end.

## Operation
- All outputs are registered.
- Reset values: s_clk=0, s_clrn=1, s_out=0, pen=0 (display blanked until the first frame completes), busy=0, done=0, state=IDLE, shift register=0, bit counter=0.
- States: IDLE, CLEAR, SHIFT, DONE.
- IDLE:
  - If start=1, capture p_data into the internal shift register, load bit counter = DATA_BITS-1, and go to CLEAR. Otherwise hold.
- CLEAR (1 cycle):
  - s_clrn=0, pen=0, busy=1, s_clk=0. Next state SHIFT.
- SHIFT (2 cycles per bit):
  - Phase 0: s_clk=0 and s_out = shift register MSB.
  - Phase 1: s_clk=1 and s_out held. At the end of phase 1, shift the register left by one and fill 0.
  - If the counter is 0, go to DONE. Otherwise decrement the counter and return to phase 0.
  - pen=0 and s_clrn=1 throughout.
- DONE (1 cycle):
  - s_clk=0, s_out=0, pen=1, done=1, busy=1. Next state IDLE.
- pen stays 1 from the first DONE until the next CLEAR or reset.
- start while busy, including in the DONE cycle, is ignored and not queued.
- A start held high re-triggers in the IDLE cycle following DONE, giving continuous refresh.
- p_data changes during a frame have no effect on that frame.
- Bit order: p_data[DATA_BITS-1] is shifted first, p_data[0] last.
- rst asserted mid-frame:
  - All outputs go to their reset values immediately and asynchronously (pen=0, s_clrn=1, s_clk=0).
  - The partial frame is abandoned, and no done pulse is produced.

## Timing
- Cycle 0 is the rising edge where start=1 is sampled in IDLE.
- Cycle 1: CLEAR; s_clrn=0, busy=1.
- Cycles 2..2*DATA_BITS+1: SHIFT. Bit k (k=0 is the MSB) is presented on s_out from cycle 2+2k. s_clk rises at the start of cycle 3+2k.
- Cycle 2*DATA_BITS+2: DONE; done=1, pen=1.
- Frame length: 2*DATA_BITS+3 cycles from acceptance to the next possible acceptance. This is 35 cycles for DATA_BITS=16.
- s_out is stable for a full clk period before and after each s_clk rising edge.
- Exactly DATA_BITS s_clk rising edges occur per frame.

## Test plan
- Reset: rst=1 for 3 cycles, then 0 with start=0 -> s_clk=0, s_clrn=1, s_out=0, pen=0, busy=0, done=0; outputs stay stable for 20 cycles.
- Single frame: DATA_BITS=16, p_data=16'hA5C3, one-cycle start.
  - s_clrn is low exactly in cycle 1.
  - The bench samples s_out at each s_clk rise and reconstructs 16'hA5C3 MSB-first.
  - Exactly 16 rising edges occur.
  - done pulses in cycle 34, and pen=1 from cycle 34 onward.
- Busy rejection: start frame with 16'hFFFF, pulse start again at cycle 10 and in the DONE cycle (cycle 34) with p_data=16'h0001 -> only one frame occurs, 16'hFFFF is shifted, and there is no second done.
- Continuous refresh: start held at 1 and p_data=16'h0F0F, changed to 16'h1234 at cycle 20.
  - First frame shifts 16'h0F0F.
  - The second frame is accepted at cycle 35 and shifts 16'h1234.
  - done pulses at cycles 34 and 69.
- Mid-frame reset: start 16'hBEEF, assert rst at cycle 12 for 2 cycles -> outputs return to reset values the same cycle with no done pulse. A subsequent start with 16'h8001 produces a clean full frame.
- Parameter sweep: DATA_BITS=8, DATA_COUNT_BITS=3, p_data=8'h81 -> 8 s_clk edges, the serial stream is 1,0,0,0,0,0,0,1, and done pulses at cycle 18.
